// File: rtl/adder_pkg.sv
// Shared definitions for the sequential wide adder and its 16-bit slice adder.
package adder_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder.sv
// 16-bit Kogge-Stone prefix adder with carry-in; purely combinational.
module adder
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int LV = $clog2(SLICE_W);

  // Level 0 holds bitwise generate/propagate; level LV holds group [i:0].
  logic [LV:0][SLICE_W-1:0] g;
  logic [LV:0][SLICE_W-1:0] p;
  logic [SLICE_W:0]         c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  // Fold the carry-in in after the prefix tree so the tree stays cin-independent.
  assign c[0]         = cin;
  assign c[SLICE_W:1] = g[LV] | (p[LV] & {SLICE_W{cin}});
  assign sum          = p[0] ^ c[SLICE_W-1:0];
  assign cout         = c[SLICE_W];

endmodule

// File: rtl/adder_wide_seq.sv
// Multi-cycle WIDTH-bit adder: one 16-bit prefix adder reused per slice,
// LSB slice first, with the slice carry held in a register between passes.
module adder_wide_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_width_chk
    $error("adder_wide_seq: WIDTH must be a non-zero multiple of 16");
  end

  state_e state, state_d;

  logic [NSLICE-1:0][SLICE_W-1:0] a_reg, b_reg, sum_reg, sum_next, res_q;
  logic [IDXW-1:0]                idx;
  logic                           carry;
  logic                           cout_q, ovf_q;
  logic                           accept;

  logic [SLICE_W-1:0] add_sum;
  logic               add_cout;

  adder u_adder (
    .a    (a_reg[idx]),
    .b    (b_reg[idx]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and handshake outputs; abort beats both in_valid and out_ready.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && !abort;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (abort)            state_d = IDLE;
        else if (idx == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Partial sum with the current slice merged in.
  always_comb begin
    sum_next      = sum_reg;
    sum_next[idx] = add_sum;
  end

  // Operand latch, slice iteration and result capture. Result registers are
  // loaded only on the final slice so outputs hold steady through RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
        carry <= in_cin;
        idx   <= '0;
      end else if (state == RUN && !abort) begin
        sum_reg <= sum_next;
        carry   <= add_cout;
        if (idx == LAST) begin
          res_q  <= sum_next;
          cout_q <= add_cout;
          ovf_q  <= signed_ovf(a_reg[NSLICE-1][SLICE_W-1],
                               b_reg[NSLICE-1][SLICE_W-1],
                               add_sum[SLICE_W-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign out_sum  = res_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_adder_wide_seq.sv
// Bench for adder_wide_seq: directed corner cases on a 64-bit instance, then
// randomized handshake traffic on 64-bit and 16-bit instances against a
// golden A+B+cin model through an expected-result queue.
module tb_adder_wide_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_cin, abort, out_ready, sel16;
  logic [63:0] in_a, in_b;

  logic        r64, v64, c64, o64;
  logic [63:0] s64;
  logic        r16, v16, c16, o16;
  logic [15:0] s16;

  adder_wide_seq #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~sel16), .in_ready(r64),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .abort(abort & ~sel16),
    .out_valid(v64), .out_ready(out_ready & ~sel16),
    .out_sum(s64), .out_cout(c64), .out_ovf(o64)
  );

  adder_wide_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & sel16), .in_ready(r16),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin),
    .abort(abort & sel16),
    .out_valid(v16), .out_ready(out_ready & sel16),
    .out_sum(s16), .out_cout(c16), .out_ovf(o16)
  );

  // Observed view of whichever instance is selected; res is {cout, sum}.
  logic        ir, ov, oo;
  logic [64:0] res;
  assign ir  = sel16 ? r16 : r64;
  assign ov  = sel16 ? v16 : v64;
  assign oo  = sel16 ? o16 : o64;
  assign res = sel16 ? {48'b0, c16, s16} : {c64, s64};

  typedef struct {
    logic [64:0] res;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin);
    exp_t        e;
    logic [64:0] full;
    if (w == 16) begin
      full  = 65'(a[15:0]) + 65'(b[15:0]) + 65'(cin);
      e.res = 65'(full[16:0]);
      e.ovf = (a[15] == b[15]) && (full[15] != a[15]);
    end else begin
      full  = 65'(a) + 65'(b) + 65'(cin);
      e.res = full;
      e.ovf = (a[63] == b[63]) && (full[63] != a[63]);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  65'(ir), 65'(1));
    check({tag, "_out_valid"}, 65'(ov), 65'(0));
    check({tag, "_res"},       res,     65'(0));
    check({tag, "_ovf"},       65'(oo), 65'(0));
  endtask

  // Present operands and hold in_valid until the handshake edge; returns #1 after it.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin);
    bit ok = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ir && !abort) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) begin
      q.push_back(model(sel16 ? 16 : 64, a, b, cin));
      @(posedge clk); #1;
    end else begin
      check("accept_timeout", 65'(ok), 65'(1));
    end
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, sampling #1 after each edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov && lat < 50);
  endtask

  task automatic take(input string tag);
    exp_t e;
    check({tag, "_have_exp"}, 65'(q.size() != 0), 65'(1));
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_valid"}, 65'(ov), 65'(1));
      check({tag, "_res"},   res,     e.res);
      check({tag, "_ovf"},   65'(oo), 65'(e.ovf));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_rand(input int n);
    int   sent = 0, got = 0, cyc = 0;
    bit   acc;
    exp_t e;
    in_valid = 1'b0; out_ready = 1'b0;
    while (got < n && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      if (!in_valid && sent < n && $urandom_range(3) != 0) begin
        in_a   = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        in_b   = ($urandom_range(7) == 0) ? 64'h8000_0000_0000_8000 : {$urandom, $urandom};
        in_cin = 1'($urandom_range(1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1));
      #1;
      acc = in_valid && ir;
      if (acc) begin
        q.push_back(model(sel16 ? 16 : 64, in_a, in_b, in_cin));
        sent++;
      end
      if (ov && out_ready) begin
        check("rnd_have_exp", 65'(q.size() != 0), 65'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rnd_res", res, e.res);
          check("rnd_ovf", 65'(oo), 65'(e.ovf));
        end
        got++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_count", 65'(got), 65'(n));
    check("rnd_drain", 65'(q.size()), 65'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    bit   stable, seen;
    logic [66:0] snap;

    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; sel16 = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    #12;
    check_reset("rst");
    @(negedge clk); rst_n = 1'b1;

    // Carry ripples through every slice.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    wait_valid(lat);
    check("t1_latency", 65'(lat), 65'(4));
    take("t1");
    check("t1_idle", 65'({ir, ov}), 65'(2'b10));

    // Positive overflow into the sign bit.
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_valid(lat);
    take("t2");

    // Negative overflow with carry out.
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    wait_valid(lat);
    take("t3");

    // Backpressure: outputs frozen, no new operands accepted.
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    wait_valid(lat);
    snap   = {ov, oo, res};
    stable = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if ({ov, oo, res} !== snap || ir) stable = 0;
    end
    check("bp_stable", 65'(stable), 65'(1));
    take("bp");
    check("bp_release", 65'({ir, ov}), 65'(2'b10));

    // Abort while the third slice is being summed.
    send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
    void'(q.pop_back());
    @(posedge clk); @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 65'({ir, ov}), 65'(2'b10));
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov) seen = 1;
    end
    check("abort_no_valid", 65'(seen), 65'(0));
    send(64'd5, 64'd7, 1'b0);
    wait_valid(lat);
    take("after_abort");

    // Abort in IDLE blocks the transfer.
    @(negedge clk);
    in_a = 64'd9; in_b = 64'd9; in_cin = 1'b0; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("idle_abort_ready0", 65'(ir), 65'(1));
    @(posedge clk); #1;
    check("idle_abort_ready1", 65'(ir), 65'(1));
    abort = 1'b0; in_valid = 1'b0;

    // Asynchronous reset mid-RUN.
    send(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    void'(q.pop_back());
    @(negedge clk); rst_n = 1'b1;
    send(64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    wait_valid(lat);
    check("post_rst_latency", 65'(lat), 65'(4));
    take("post_rst");

    // Random traffic, both widths.
    sel16 = 1'b0;
    run_rand(1000);
    sel16 = 1'b1;
    run_rand(1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
